pingpong_operand_buffer: RTL and testbench
==========================================

# pingpong_operand_buffer

Double-buffered (ping-pong) operand store that sits directly upstream of the 2:1 operand mux in the Simple GAN datapath. A producer streams words into one bank while the consumer side drains the other bank. The block presents the same-index word from both banks together with a bank-select bit, and these drive the mux's A, B and selector inputs. Bank ownership swaps automatically on full/empty, so the mux always selects the bank that holds a complete frame.

## Interface
- DWIDTH, 32, word width; equals the downstream mux width.
- DEPTH, 16, words per bank; power of two, at least 2.
- AWIDTH, $clog2(DEPTH), index width (derived).

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- wr_valid  in  1  producer has a word.
- wr_data  in  DWIDTH  producer word.
- wr_ready  out  1  write accepted this cycle when wr_valid and wr_ready are both 1.
- rd_ready  in  1  consumer accepts the presented word.
- rd_valid  out  1  rd_data_a, rd_data_b and rd_sel are valid.
- rd_data_a  out  DWIDTH  bank 0 word at the current read index (mux input A).
- rd_data_b  out  DWIDTH  bank 1 word at the current read index (mux input B).
- rd_sel  out  1  bank being drained: 0 selects A, 1 selects B (mux selector).
- rd_last  out  1  presented word is index DEPTH-1 of its bank.
- bank_full  out  2  per-bank full flags, bit i for bank i.

## Operation
- Storage: two arrays mem0 and mem1, each DEPTH x DWIDTH. Arrays are not reset.
- Write side:
  - wr_bank and wr_ptr select the target location.
  - wr_ready = ~bank_full[wr_bank].
  - On a write handshake, mem[wr_bank][wr_ptr] = wr_data.
  - If wr_ptr == DEPTH-1: bank_full[wr_bank] is set, wr_bank toggles and wr_ptr wraps to 0. Otherwise wr_ptr increments.
- Read FSM, states IDLE, FETCH, PRESENT:
  - IDLE: rd_valid=0. If bank_full[rd_bank], go to FETCH.
  - FETCH: register rd_data_a=mem0[rd_ptr], rd_data_b=mem1[rd_ptr], and rd_last=(rd_ptr==DEPTH-1). Go to PRESENT.
  - PRESENT: rd_valid=1. Outputs hold while rd_ready=0.
  - PRESENT with handshake and not last: rd_ptr increments, go to FETCH.
  - PRESENT with handshake and last: clear bank_full[rd_bank], toggle rd_bank, rd_ptr returns to 0, go to IDLE.
- rd_sel = rd_bank. It is constant for the whole drain of a bank.
- Simultaneous events:
  - A write that fills one bank and a read that releases the other bank in the same cycle both take effect.
  - The same bank can never be set and cleared in the same cycle, because writes target only non-full banks and releases apply only to full banks.
- Both banks full: wr_ready=0 until the reader releases a bank. The writer then resumes in the released bank, which is the bank wr_bank already points at.
- Reset (any cycle, including mid-fill or mid-drain), all outputs and state to zero:
  - FSM=IDLE, wr_ptr=rd_ptr=0, wr_bank=rd_bank=0, bank_full=00.
  - rd_valid=0, rd_last=0, rd_data_a=rd_data_b=0, rd_sel=0.
  - wr_ready reads 1 in the first cycle after reset.
  - Any partial frame is discarded.

## Timing
- Fill-to-present latency: if the final write of a bank handshakes in cycle c, bank_full is visible in c+1, FETCH occurs in c+2 and rd_valid=1 in c+3. This assumes the reader is idle.
- Intra-bank throughput: a handshake in PRESENT cycle p gives FETCH in p+1 and the next rd_valid in p+2, i.e. 1 word per 2 cycles with rd_ready held at 1.
- Release-to-write: release handshake in cycle r gives wr_ready=1 for that bank in r+1.
- Release-to-next-bank: if the other bank is full at release cycle r, the FSM is in IDLE in r+1, FETCH in r+2 and rd_valid=1 in r+3.
- Write throughput: 1 word/cycle while wr_ready=1.
- Data outputs are registered; no combinational path from inputs to rd_* outputs.

## Test plan
- Reset, then 16 writes of 0x00..0x0F, rd_ready=1:
  - rd_valid first rises 3 cycles after the 16th write.
  - rd_sel=0 and rd_data_a steps 0x00..0x0F, one word every 2 cycles.
  - rd_last=1 only on 0x0F; bank_full returns to 00.
- 32 back-to-back writes 0x100..0x11F with rd_ready=0:
  - bank_full=11, and wr_ready=0 from the 33rd cycle on.
  - After bank 0 drains, the last handshake is followed by wr_ready=1 one cycle later, and rd_sel=1 with rd_data_b=0x110 three cycles after that handshake.
- Consumer stall: drop rd_ready for 5 cycles while presenting 0x07. rd_data_a, rd_valid and rd_last hold, and no words are skipped or repeated.
- Simultaneous fill and release: the final write into bank 1 lands in the same cycle as the release handshake of bank 0. Next cycle bank_full=10, wr_bank=0, rd_sel=1.
- Reset mid-drain at word 5 of bank 0 with bank 1 half-written:
  - Next cycle all outputs are 0, bank_full=00, wr_ready=1.
  - A fresh 16-word fill presents from index 0 of bank 0.

Source files
------------

// File: rtl/pingpong_operand_buffer.sv
// Ping-pong operand store feeding the 2:1 operand mux (A=bank0, B=bank1, sel=rd_sel).
// Ports: clk, rst_n, wr_valid/wr_data/wr_ready in, rd_ready/rd_valid/rd_data_a/b/rd_sel/rd_last/bank_full out.
module pingpong_operand_buffer #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 16,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DWIDTH-1:0] rd_data_a,
  output logic [DWIDTH-1:0] rd_data_b,
  output logic              rd_sel,
  output logic              rd_last,
  output logic [1:0]        bank_full
);

  localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } state_e;

  logic [DWIDTH-1:0] mem0 [DEPTH];
  logic [DWIDTH-1:0] mem1 [DEPTH];

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic [DWIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [DWIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic              rd_last_q, rd_last_d;

  logic wr_fire;
  logic rd_fire;
  logic rd_release;
  logic do_fetch;

  assign wr_ready = ~bank_full_q[wr_bank_q];
  assign wr_fire  = wr_valid & wr_ready;

  // Storage is not reset; only written on a handshake.
  always_ff @(posedge clk) begin
    if (wr_fire && !wr_bank_q) mem0[wr_ptr_q] <= wr_data;
    if (wr_fire &&  wr_bank_q) mem1[wr_ptr_q] <= wr_data;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bank_full_q[rd_bank_q]) state_d = FETCH;
      FETCH:   state_d = PRESENT;
      PRESENT: if (rd_ready) state_d = rd_last_q ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    rd_valid   = (state_q == PRESENT);
    do_fetch   = (state_q == FETCH);
    rd_fire    = rd_valid & rd_ready;
    rd_release = rd_fire & rd_last_q;
  end

  // Pointer, bank and flag updates
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    wr_bank_d   = wr_bank_q;
    rd_ptr_d    = rd_ptr_q;
    rd_bank_d   = rd_bank_q;
    bank_full_d = bank_full_q;
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    rd_last_d   = rd_last_q;

    if (wr_fire) begin
      if (wr_ptr_q == LAST_IDX) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d = ~wr_bank_q;
        wr_ptr_d  = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    // Writes only hit non-full banks and releases only full ones,
    // so set and clear never collide on one bit.
    if (rd_release) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d = ~rd_bank_q;
      rd_ptr_d  = '0;
    end else if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (do_fetch) begin
      rd_data_a_d = mem0[rd_ptr_q];
      rd_data_b_d = mem1[rd_ptr_q];
      rd_last_d   = (rd_ptr_q == LAST_IDX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_ptr_q    <= '0;
      rd_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_last_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_bank_q   <= wr_bank_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_bank_q   <= rd_bank_d;
      bank_full_q <= bank_full_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_last_q   <= rd_last_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_last   = rd_last_q;
  assign rd_sel    = rd_bank_q;
  assign bank_full = bank_full_q;

endmodule

// File: tb/tb_pingpong_operand_buffer.sv
// Directed bench for pingpong_operand_buffer.
// Inputs driven and outputs checked on the falling edge.
module tb_pingpong_operand_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        rd_sel;
  logic        rd_last;
  logic [1:0]  bank_full;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  pingpong_operand_buffer #(.DWIDTH(32), .DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_sel    (rd_sel),
    .rd_last   (rd_last),
    .bank_full (bank_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    chk("wr_ready", 32'(wr_ready), 32'd1);
    cyc();
  endtask

  task automatic pres(input logic sel, input logic [31:0] d,
                      input logic last);
    chk("rd_valid", 32'(rd_valid), 32'd1);
    chk("rd_sel", 32'(rd_sel), 32'(sel));
    chk("rd_data", sel ? rd_data_b : rd_data_a, d);
    chk("rd_last", 32'(rd_last), 32'(last));
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_last", 32'(rd_last), 32'd0);
    chk("rst_a", rd_data_a, 32'd0);
    chk("rst_b", rd_data_b, 32'd0);
    chk("rst_sel", 32'(rd_sel), 32'd0);
    chk("rst_full", 32'(bank_full), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    cyc();
    do_reset();

    // Fill bank 0 with 0..15, drain with a 5-cycle stall on word 7
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) wr(32'(i));
    wr_valid = 1'b0;
    chk("t1_full", 32'(bank_full), 32'd1);
    chk("t1_c1_valid", 32'(rd_valid), 32'd0);
    cyc();
    chk("t1_c2_valid", 32'(rd_valid), 32'd0);
    cyc();
    for (int i = 0; i < 16; i++) begin
      pres(1'b0, 32'(i), i == 15);
      if (i == 7) begin
        rd_ready = 1'b0;
        repeat (5) begin
          cyc();
          pres(1'b0, 32'd7, 1'b0);
        end
        rd_ready = 1'b1;
      end
      cyc();
      chk("t1_gap_valid", 32'(rd_valid), 32'd0);
      if (i < 15) cyc();
    end
    chk("t1_empty", 32'(bank_full), 32'd0);
    chk("t1_wr_ready", 32'(wr_ready), 32'd1);

    // 32 back-to-back writes, both banks fill
    rd_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 32; i++) wr(32'h100 + 32'(i));
    wr_valid = 1'b0;
    chk("t2_wr_ready", 32'(wr_ready), 32'd0);
    chk("t2_full", 32'(bank_full), 32'd3);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pres(1'b0, 32'h100 + 32'(i), i == 15);
      cyc();
      if (i < 15) begin
        chk("t2_gap_valid", 32'(rd_valid), 32'd0);
        cyc();
      end
    end
    chk("t2_r1_wr_ready", 32'(wr_ready), 32'd1);
    chk("t2_r1_full", 32'(bank_full), 32'd2);
    chk("t2_r1_valid", 32'(rd_valid), 32'd0);
    cyc();
    chk("t2_r2_valid", 32'(rd_valid), 32'd0);
    cyc();
    pres(1'b1, 32'h110, 1'b0);
    chk("t2_r3_a", rd_data_a, 32'h100);
    rd_ready = 1'b0;

    // Final write into bank 1 coincides with release of bank 0
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) wr(32'h200 + 32'(i));
    wr_valid = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 15; i++) begin
      pres(1'b0, 32'h200 + 32'(i), 1'b0);
      cyc();
      chk("t4_gap_valid", 32'(rd_valid), 32'd0);
      cyc();
    end
    rd_ready = 1'b0;
    pres(1'b0, 32'h20F, 1'b1);
    for (int i = 0; i < 15; i++) wr(32'h210 + 32'(i));
    wr_valid = 1'b0;
    pres(1'b0, 32'h20F, 1'b1);
    chk("t4_pre_full", 32'(bank_full), 32'd1);
    wr_valid = 1'b1;
    wr_data  = 32'h21F;
    rd_ready = 1'b1;
    chk("t4_pre_wr_ready", 32'(wr_ready), 32'd1);
    cyc();
    wr_valid = 1'b0;
    chk("t4_full", 32'(bank_full), 32'd2);
    chk("t4_sel", 32'(rd_sel), 32'd1);
    chk("t4_wr_ready", 32'(wr_ready), 32'd1);
    chk("t4_valid", 32'(rd_valid), 32'd0);
    cyc();
    cyc();
    pres(1'b1, 32'h210, 1'b0);
    rd_ready = 1'b0;

    // Reset mid-drain at word 5 with bank 1 half-written
    do_reset();
    for (int i = 0; i < 16; i++) wr(32'h300 + 32'(i));
    for (int i = 0; i < 8; i++) wr(32'h310 + 32'(i));
    wr_valid = 1'b0;
    chk("t5_full", 32'(bank_full), 32'd1);
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pres(1'b0, 32'h300 + 32'(i), 1'b0);
      cyc();
      chk("t5_gap_valid", 32'(rd_valid), 32'd0);
      cyc();
    end
    pres(1'b0, 32'h305, 1'b0);
    rd_ready = 1'b0;
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) wr(32'h400 + 32'(i));
    wr_valid = 1'b0;
    chk("t5_refill_full", 32'(bank_full), 32'd1);
    cyc();
    cyc();
    pres(1'b0, 32'h400, 1'b0);
    cyc();
    chk("t5_gap_valid", 32'(rd_valid), 32'd0);
    cyc();
    pres(1'b0, 32'h401, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
